// File: rtl/sweep_tuning_ctrl_pkg.sv
// Shared encodings and default widths for the sweep tuning controller.
// Imported by the interface, the dwell timer and the sweep controller top.
package sweep_tuning_ctrl_pkg;

    localparam int DEF_PHASE_WIDTH = 32;
    localparam int DEF_DWELL_WIDTH = 16;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        HOLD = ST_HOLD
    } state_t;

    typedef enum logic {
        DIR_UP = 1'b0,
        DIR_DN = 1'b1
    } dir_t;

endpackage

// File: rtl/sweep_tuning_ctrl_if.sv
// Command/status bundle between the sequencer (master) and the sweep
// controller (slave).
interface sweep_tuning_ctrl_if
    import sweep_tuning_ctrl_pkg::*;
#(
    parameter int PHASE_WIDTH = DEF_PHASE_WIDTH,
    parameter int DWELL_WIDTH = DEF_DWELL_WIDTH
);

    logic                   start;
    logic                   abort;
    logic                   loop_en;
    logic [PHASE_WIDTH-1:0] f_start;
    logic [PHASE_WIDTH-1:0] f_stop;
    logic [PHASE_WIDTH-1:0] f_step;
    logic [DWELL_WIDTH-1:0] dwell;
    logic [PHASE_WIDTH-1:0] phase_inc;
    logic                   busy;
    logic                   done;

    modport master (
        output start, abort, loop_en,
        output f_start, f_stop, f_step, dwell,
        input  phase_inc, busy, done
    );

    modport slave (
        input  start, abort, loop_en,
        input  f_start, f_stop, f_step, dwell,
        output phase_inc, busy, done
    );

endinterface

// File: rtl/sweep_dwell_timer.sv
// Per-step dwell counter: counts 0..limit while enabled and flags the
// terminal count, wrapping back to 0 on that cycle.
module sweep_dwell_timer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] limit,
    output logic             tc
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] cnt;

    assign tc = (cnt == limit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tc ? '0 : cnt + ONE;
        end
    end

endmodule

// File: rtl/sweep_tuning_ctrl.sv
// Linear frequency sweep controller producing the accumulator tuning word.
// Define SWEEP_TRIANGLE_EN for up/down (triangle) looping instead of sawtooth.
module sweep_tuning_ctrl
    import sweep_tuning_ctrl_pkg::*;
#(
    parameter int PHASE_WIDTH = DEF_PHASE_WIDTH,
    parameter int DWELL_WIDTH = DEF_DWELL_WIDTH
) (
    input logic               clk,
    input logic               rst_n,
    sweep_tuning_ctrl_if.slave bus
);

    localparam int PW = PHASE_WIDTH;

    state_t                 state;
    logic [PW-1:0]          phase_q;
    logic [PW-1:0]          f_start_s;
    logic [PW-1:0]          f_stop_s;
    logic [PW-1:0]          f_step_s;
    logic [DWELL_WIDTH-1:0] dwell_s;
    logic                   loop_s;
    logic                   degen_s;
    logic                   busy_q;
    logic                   done_q;

    logic                   go;
    logic                   tc;
    logic                   at_stop;
    logic [PW:0]            up_sum;
    logic [PW-1:0]          up_val;

    assign go = bus.start && !bus.abort && (state != RUN);

    // Extra carry bit makes an overflowing step compare above f_stop.
    assign up_sum  = {1'b0, phase_q} + {1'b0, f_step_s};
    assign up_val  = (up_sum > {1'b0, f_stop_s}) ? f_stop_s : up_sum[PW-1:0];
    assign at_stop = degen_s || (phase_q == f_stop_s);

`ifdef SWEEP_TRIANGLE_EN
    dir_t          dir;
    logic [PW:0]   dn_diff;
    logic [PW-1:0] dn_val;

    assign dn_diff = {1'b0, phase_q} - {1'b0, f_step_s};
    assign dn_val  = (dn_diff[PW] || dn_diff[PW-1:0] < f_start_s)
                   ? f_start_s : dn_diff[PW-1:0];
`endif

    sweep_dwell_timer #(
        .WIDTH(DWELL_WIDTH)
    ) u_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .load (go || bus.abort),
        .en   (state == RUN),
        .limit(dwell_s),
        .tc   (tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            phase_q   <= '0;
            f_start_s <= '0;
            f_stop_s  <= '0;
            f_step_s  <= '0;
            dwell_s   <= '0;
            loop_s    <= 1'b0;
            degen_s   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef SWEEP_TRIANGLE_EN
            dir       <= DIR_UP;
`endif
        end else begin
            done_q <= 1'b0;
            if (bus.abort) begin
                state   <= IDLE;
                phase_q <= '0;
                busy_q  <= 1'b0;
`ifdef SWEEP_TRIANGLE_EN
                dir     <= DIR_UP;
`endif
            end else if (go) begin
                state     <= RUN;
                f_start_s <= bus.f_start;
                f_stop_s  <= bus.f_stop;
                f_step_s  <= bus.f_step;
                dwell_s   <= bus.dwell;
                loop_s    <= bus.loop_en;
                degen_s   <= (bus.f_step == '0) || (bus.f_start >= bus.f_stop);
                phase_q   <= bus.f_start;
                busy_q    <= 1'b1;
`ifdef SWEEP_TRIANGLE_EN
                dir       <= DIR_UP;
`endif
            end else if (state == RUN && tc) begin
`ifdef SWEEP_TRIANGLE_EN
                if (!degen_s && dir == DIR_DN) begin
                    if (phase_q == f_start_s) begin
                        dir     <= DIR_UP;
                        phase_q <= up_val;
                    end else begin
                        phase_q <= dn_val;
                    end
                end else
`endif
                if (at_stop) begin
                    if (!loop_s) begin
                        state  <= HOLD;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
`ifdef SWEEP_TRIANGLE_EN
                    else if (degen_s) begin
                        phase_q <= f_start_s;
                    end else begin
                        dir     <= DIR_DN;
                        phase_q <= dn_val;
                    end
`else
                    else begin
                        phase_q <= f_start_s;
                    end
`endif
                end else begin
                    phase_q <= up_val;
                end
            end
        end
    end

    assign bus.phase_inc = phase_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_sweep_tuning_ctrl.sv
// Scoreboard bench for sweep_tuning_ctrl: per-cycle expected
// {phase_inc, busy, done} are queued with the stimulus and popped each cycle.
module tb_sweep_tuning_ctrl;

    localparam int PW = 32;
    localparam int DW = 16;

    typedef struct packed {
        logic [PW-1:0] ph;
        logic          busy;
        logic          done;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;

    exp_t sb[$];
    exp_t e;
    int   vectors     = 0;
    int   miscompares = 0;

    sweep_tuning_ctrl_if #(.PHASE_WIDTH(PW), .DWELL_WIDTH(DW)) bus ();

    sweep_tuning_ctrl #(.PHASE_WIDTH(PW), .DWELL_WIDTH(DW)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, want $finish");
        $fatal(1, "watchdog");
    end

    task automatic push(input logic [PW-1:0] ph, input int n,
                        input logic b, input logic d);
        exp_t x;
        x.ph   = ph;
        x.busy = b;
        x.done = d;
        repeat (n) sb.push_back(x);
    endtask

    task automatic apply_start(input logic [PW-1:0] fs, input logic [PW-1:0] fe,
                               input logic [PW-1:0] st, input logic [DW-1:0] dw,
                               input logic lp);
        bus.f_start = fs;
        bus.f_stop  = fe;
        bus.f_step  = st;
        bus.dwell   = dw;
        bus.loop_en = lp;
        bus.start   = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    task automatic apply_abort();
        bus.abort = 1'b1;
        @(posedge clk);
        #1 bus.abort = 1'b0;
    endtask

    task automatic test_reset();
        push('0, 3, 1'b0, 1'b0);
        while (sb.size() != 0) begin
            @(negedge clk);
            e = sb.pop_front();
            vectors++;
            if ({bus.phase_inc, bus.busy, bus.done} !== e)
                begin
                miscompares++;
                $display("FAIL reset: got %0h/%b/%b want %0h/%b/%b",
                         bus.phase_inc, bus.busy, bus.done, e.ph, e.busy, e.done);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single_shot();
        apply_start(100, 130, 10, 2, 1'b0);
        push(100, 3, 1'b1, 1'b0);
        push(110, 3, 1'b1, 1'b0);
        push(120, 3, 1'b1, 1'b0);
        push(130, 3, 1'b1, 1'b0);
        push(130, 1, 1'b0, 1'b1);
        push(130, 2, 1'b0, 1'b0);
        while (sb.size() != 0) begin
            @(negedge clk);
            e = sb.pop_front();
            vectors++;
            if ({bus.phase_inc, bus.busy, bus.done} !== e) begin
                miscompares++;
                $display("FAIL single: got %0d/%b/%b want %0d/%b/%b",
                         bus.phase_inc, bus.busy, bus.done, e.ph, e.busy, e.done);
            end
        end
    endtask

    task automatic test_clamp();
        apply_start(100, 125, 10, 0, 1'b0);
        push(100, 1, 1'b1, 1'b0);
        push(110, 1, 1'b1, 1'b0);
        push(120, 1, 1'b1, 1'b0);
        push(125, 1, 1'b1, 1'b0);
        push(125, 1, 1'b0, 1'b1);
        push(125, 1, 1'b0, 1'b0);
        while (sb.size() != 0) begin
            @(negedge clk);
            e = sb.pop_front();
            vectors++;
            if ({bus.phase_inc, bus.busy, bus.done} !== e) begin
                miscompares++;
                $display("FAIL clamp: got %0d/%b/%b want %0d/%b/%b",
                         bus.phase_inc, bus.busy, bus.done, e.ph, e.busy, e.done);
            end
        end
    endtask

    task automatic test_overflow();
        apply_start(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 0, 1'b0);
        push(32'hFFFF_FFF0, 1, 1'b1, 1'b0);
        push(32'hFFFF_FFFF, 1, 1'b1, 1'b0);
        push(32'hFFFF_FFFF, 1, 1'b0, 1'b1);
        push(32'hFFFF_FFFF, 1, 1'b0, 1'b0);
        while (sb.size() != 0) begin
            @(negedge clk);
            e = sb.pop_front();
            vectors++;
            if ({bus.phase_inc, bus.busy, bus.done} !== e) begin
                miscompares++;
                $display("FAIL overflow: got %0h/%b/%b want %0h/%b/%b",
                         bus.phase_inc, bus.busy, bus.done, e.ph, e.busy, e.done);
            end
        end
        apply_abort();
        push('0, 2, 1'b0, 1'b0);
        while (sb.size() != 0) begin
            @(negedge clk);
            e = sb.pop_front();
            vectors++;
            if ({bus.phase_inc, bus.busy, bus.done} !== e) begin
                miscompares++;
                $display("FAIL hold_abort: got %0h/%b/%b want %0h/%b/%b",
                         bus.phase_inc, bus.busy, bus.done, e.ph, e.busy, e.done);
            end
        end
    endtask

    task automatic test_loop();
        apply_start(0, 20, 10, 1, 1'b1);
        push(0, 2, 1'b1, 1'b0);
        push(10, 2, 1'b1, 1'b0);
        push(20, 2, 1'b1, 1'b0);
`ifdef SWEEP_TRIANGLE_EN
        push(10, 2, 1'b1, 1'b0);
        push(0, 2, 1'b1, 1'b0);
        push(10, 2, 1'b1, 1'b0);
`else
        push(0, 2, 1'b1, 1'b0);
        push(10, 2, 1'b1, 1'b0);
        push(20, 2, 1'b1, 1'b0);
        push(0, 2, 1'b1, 1'b0);
        push(10, 2, 1'b1, 1'b0);
`endif
        while (sb.size() != 0) begin
            @(negedge clk);
            e = sb.pop_front();
            vectors++;
            if ({bus.phase_inc, bus.busy, bus.done} !== e) begin
                miscompares++;
                $display("FAIL loop: got %0d/%b/%b want %0d/%b/%b",
                         bus.phase_inc, bus.busy, bus.done, e.ph, e.busy, e.done);
            end
        end
        apply_abort();
        push('0, 2, 1'b0, 1'b0);
        while (sb.size() != 0) begin
            @(negedge clk);
            e = sb.pop_front();
            vectors++;
            if ({bus.phase_inc, bus.busy, bus.done} !== e) begin
                miscompares++;
                $display("FAIL loop_abort: got %0d/%b/%b want %0d/%b/%b",
                         bus.phase_inc, bus.busy, bus.done, e.ph, e.busy, e.done);
            end
        end
    endtask

`ifdef SWEEP_TRIANGLE_EN
    task automatic test_triangle();
        apply_start(0, 20, 10, 0, 1'b1);
        push(0, 1, 1'b1, 1'b0);
        push(10, 1, 1'b1, 1'b0);
        push(20, 1, 1'b1, 1'b0);
        push(10, 1, 1'b1, 1'b0);
        push(0, 1, 1'b1, 1'b0);
        push(10, 1, 1'b1, 1'b0);
        push(20, 1, 1'b1, 1'b0);
        push(10, 1, 1'b1, 1'b0);
        while (sb.size() != 0) begin
            @(negedge clk);
            e = sb.pop_front();
            vectors++;
            if ({bus.phase_inc, bus.busy, bus.done} !== e) begin
                miscompares++;
                $display("FAIL triangle: got %0d/%b/%b want %0d/%b/%b",
                         bus.phase_inc, bus.busy, bus.done, e.ph, e.busy, e.done);
            end
        end
        apply_abort();
        push('0, 1, 1'b0, 1'b0);
        while (sb.size() != 0) begin
            @(negedge clk);
            e = sb.pop_front();
            vectors++;
            if ({bus.phase_inc, bus.busy, bus.done} !== e) begin
                miscompares++;
                $display("FAIL triangle_abort: got %0d/%b/%b want %0d/%b/%b",
                         bus.phase_inc, bus.busy, bus.done, e.ph, e.busy, e.done);
            end
        end
    endtask
`endif

    task automatic test_degenerate();
        apply_start(50, 40, 10, 2, 1'b0);
        push(50, 3, 1'b1, 1'b0);
        push(50, 1, 1'b0, 1'b1);
        push(50, 1, 1'b0, 1'b0);
        while (sb.size() != 0) begin
            @(negedge clk);
            e = sb.pop_front();
            vectors++;
            if ({bus.phase_inc, bus.busy, bus.done} !== e) begin
                miscompares++;
                $display("FAIL degenerate: got %0d/%b/%b want %0d/%b/%b",
                         bus.phase_inc, bus.busy, bus.done, e.ph, e.busy, e.done);
            end
        end
        apply_abort();
        push('0, 1, 1'b0, 1'b0);
        while (sb.size() != 0) begin
            @(negedge clk);
            e = sb.pop_front();
            vectors++;
            if ({bus.phase_inc, bus.busy, bus.done} !== e) begin
                miscompares++;
                $display("FAIL degenerate_abort: got %0d/%b/%b want %0d/%b/%b",
                         bus.phase_inc, bus.busy, bus.done, e.ph, e.busy, e.done);
            end
        end
    endtask

    task automatic test_priority();
        bus.f_start = 77;
        bus.f_stop  = 99;
        bus.f_step  = 1;
        bus.dwell   = 0;
        bus.loop_en = 1'b0;
        bus.start   = 1'b1;
        bus.abort   = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        push('0, 3, 1'b0, 1'b0);
        while (sb.size() != 0) begin
            @(negedge clk);
            e = sb.pop_front();
            vectors++;
            if ({bus.phase_inc, bus.busy, bus.done} !== e) begin
                miscompares++;
                $display("FAIL priority: got %0d/%b/%b want %0d/%b/%b",
                         bus.phase_inc, bus.busy, bus.done, e.ph, e.busy, e.done);
            end
        end
    endtask

    task automatic test_start_while_busy();
        apply_start(100, 130, 10, 2, 1'b0);
        push(100, 3, 1'b1, 1'b0);
        push(110, 3, 1'b1, 1'b0);
        push(120, 3, 1'b1, 1'b0);
        push(130, 3, 1'b1, 1'b0);
        push(130, 1, 1'b0, 1'b1);
        push(130, 1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            e = sb.pop_front();
            vectors++;
            if ({bus.phase_inc, bus.busy, bus.done} !== e) begin
                miscompares++;
                $display("FAIL busy_start: got %0d/%b/%b want %0d/%b/%b",
                         bus.phase_inc, bus.busy, bus.done, e.ph, e.busy, e.done);
            end
        end
        // Retarget the inputs and re-request; the running sweep must not notice.
        apply_start(500, 900, 100, 0, 1'b1);
        while (sb.size() != 0) begin
            @(negedge clk);
            e = sb.pop_front();
            vectors++;
            if ({bus.phase_inc, bus.busy, bus.done} !== e) begin
                miscompares++;
                $display("FAIL busy_start: got %0d/%b/%b want %0d/%b/%b",
                         bus.phase_inc, bus.busy, bus.done, e.ph, e.busy, e.done);
            end
        end
    endtask

    task automatic test_async_reset();
        apply_start(100, 130, 10, 2, 1'b0);
        push(100, 3, 1'b1, 1'b0);
        push(110, 2, 1'b1, 1'b0);
        while (sb.size() != 0) begin
            @(negedge clk);
            e = sb.pop_front();
            vectors++;
            if ({bus.phase_inc, bus.busy, bus.done} !== e) begin
                miscompares++;
                $display("FAIL pre_reset: got %0d/%b/%b want %0d/%b/%b",
                         bus.phase_inc, bus.busy, bus.done, e.ph, e.busy, e.done);
            end
        end
        #1 rst_n = 1'b0;
        push('0, 1, 1'b0, 1'b0);
        #1;
        e = sb.pop_front();
        vectors++;
        if ({bus.phase_inc, bus.busy, bus.done} !== e) begin
            miscompares++;
            $display("FAIL async_reset: got %0d/%b/%b want %0d/%b/%b",
                     bus.phase_inc, bus.busy, bus.done, e.ph, e.busy, e.done);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n       = 1'b0;
        bus.start   = 1'b0;
        bus.abort   = 1'b0;
        bus.loop_en = 1'b0;
        bus.f_start = '0;
        bus.f_stop  = '0;
        bus.f_step  = '0;
        bus.dwell   = '0;
        test_reset();
        test_single_shot();
        test_clamp();
        test_overflow();
        test_loop();
`ifdef SWEEP_TRIANGLE_EN
        test_triangle();
`endif
        test_degenerate();
        test_priority();
        test_start_while_busy();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sweep_tuning_ctrl.md
Name: sweep_tuning_ctrl

Overview:
- Linear-frequency-sweep controller that generates the phase increment (tuning word) driving the phase accumulator directly downstream.
- Steps the tuning word from a start value to a stop value in fixed increments, holding each value for a programmable dwell.
- Supports single-shot and looping sweeps; provides a busy flag and a done pulse for the sequencing logic above it.

Parameters:
- PHASE_WIDTH, 32, width of all tuning-word values (matches the accumulator phase width).
- DWELL_WIDTH, 16, width of the per-step dwell counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request to begin a sweep.
- abort  in  1  single-cycle request to stop immediately.
- loop_en  in  1  1 = restart from f_start after reaching f_stop; sampled at start.
- f_start  in  PHASE_WIDTH  first tuning word; sampled at start.
- f_stop  in  PHASE_WIDTH  final tuning word; sampled at start.
- f_step  in  PHASE_WIDTH  increment per step; sampled at start.
- dwell  in  DWELL_WIDTH  cycles per step minus 1 (0 = 1 cycle per step); sampled at start.
- phase_inc  out  PHASE_WIDTH  tuning word to the accumulator, registered.
- busy  out  1  high while a sweep is in progress.
- done  out  1  one-cycle pulse when a single-shot sweep completes.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, phase_inc=0, busy=0, done=0, dwell counter=0, shadow registers=0.
- States: IDLE, RUN, HOLD.
- IDLE -> RUN on start=1 and abort=0.
  - Latches f_start, f_stop, f_step, dwell and loop_en into shadow registers.
  - phase_inc=f_start on the next edge; busy=1 from that edge.
- RUN: the dwell counter counts 0..dwell_s. When the counter equals dwell_s, the step is evaluated:
  - next = cur + f_step_s, computed PHASE_WIDTH+1 bits wide.
  - If cur == f_stop_s: end of sweep.
  - Else if next > f_stop_s or next overflows bit PHASE_WIDTH: phase_inc=f_stop_s (clamp). The clamped value gets its own full dwell.
  - Else phase_inc=next[PHASE_WIDTH-1:0].
  - The counter resets to 0 on every step.
- End of sweep:
  - loop_en_s=1: phase_inc=f_start_s and RUN continues; done not asserted.
  - loop_en_s=0: go to HOLD, done=1 for one cycle, busy=0; phase_inc holds f_stop_s.
- Degenerate sweep (f_step_s=0 or f_start_s>=f_stop_s): cur is treated as at f_stop after the first dwell. Single-shot emits done after dwell_s+1 cycles with phase_inc=f_start_s; looping holds f_start_s indefinitely.
- HOLD: phase_inc holds its value; start begins a new sweep exactly as from IDLE; abort goes to IDLE.
- abort in RUN or HOLD: next edge gives IDLE, phase_inc=0, busy=0, done=0.
- abort and start in the same cycle: abort wins.
- start while RUN is ignored.
- Latency: start at edge N gives phase_inc=f_start and busy=1 after edge N+1. Each value is held exactly dwell_s+1 cycles.
- Input changes during a sweep have no effect; only the shadow copies are used.

Optional Feature:
- Macro SWEEP_TRIANGLE_EN.
- Defined:
  - Looping sweeps reverse direction at f_stop_s instead of reloading: decrement by f_step_s, clamp at f_start_s, then reverse again.
  - f_stop_s and f_start_s are each held for one dwell at the turn.
  - Adds a direction register, reset to up.
- Undefined: sawtooth loop as specified above; no direction register.

Decomposition:
- Shared package holds:
  - State encoding localparams: IDLE=2'd0, RUN=2'd1, HOLD=2'd2.
  - Default widths PHASE_WIDTH/DWELL_WIDTH, so the sweep controller and the accumulator agree.
- Natural sub-module: sweep_dwell_timer (load, enable, terminal-count output).
- Clamp/compare logic stays inline.

Test Plan:
- Single-shot sweep: f_start=100, f_stop=130, f_step=10, dwell=2, loop_en=0 -> phase_inc 100,110,120,130, each held 3 cycles; done pulses one cycle after the 130 dwell; busy falls with done.
- Clamp: f_start=100, f_stop=125, f_step=10, dwell=0 -> phase_inc 100,110,120,125, then done; 125 is held 1 cycle.
- Overflow: PHASE_WIDTH=32, f_start=32'hFFFF_FFF0, f_stop=32'hFFFF_FFFF, f_step=32'h20 -> second value is 32'hFFFF_FFFF (clamped, no wrap), then done.
- Loop: f_start=0, f_stop=20, f_step=10, dwell=1, loop_en=1 -> sequence 0,10,20,0,10,... with no done pulse; abort mid-sweep gives phase_inc=0 and busy=0 on the next edge.
- Reset and priority: rst_n low mid-RUN -> all outputs 0 immediately (asynchronous); start with abort in the same cycle in IDLE -> stays IDLE; start while busy -> ignored, sequence unchanged.
- SWEEP_TRIANGLE_EN: f_start=0, f_stop=20, f_step=10, dwell=0, loop_en=1 -> 0,10,20,10,0,10,20,...
